// File: rtl/jtframe_rom_nslot_pkg.sv
// Shared definitions for the N-slot SDRAM ROM arbiter:
// data-width codes, FSM states and the slot address mapper.
package jtframe_rom_nslot_pkg;

    localparam int WW = 22;

    localparam logic [1:0] DW8  = 2'd0;
    localparam logic [1:0] DW16 = 2'd1;
    localparam logic [1:0] DW32 = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    // native address -> 32-bit aligned SDRAM word address (wraps)
    function automatic logic [WW-1:0] map_word(
        input logic [1:0]    dw,
        input logic [WW-1:0] off,
        input logic [WW-1:0] a
    );
        logic [WW-1:0] w;
        unique case (dw)
            DW8:     w = off + (a >> 1);
            DW16:    w = off + a;
            default: w = off + (a << 1);
        endcase
        if (dw != DW32) w[0] = 1'b0;
        return w;
    endfunction

endpackage

// File: rtl/jtframe_rom_slotcache.sv
// One-line (32-bit) cache for a single ROM slot: tag, data,
// valid bit, hit detection, data lane select and word mapping.
module jtframe_rom_slotcache
    import jtframe_rom_nslot_pkg::*;
#(
    parameter int              MAXAW  = 18,
    parameter logic [1:0]      DW     = DW8,
    parameter logic [WW-1:0]   OFFSET = '0
) (
    input  logic             clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_cs,
    input  logic [MAXAW-1:0] i_addr,
    input  logic             i_we,
    input  logic [MAXAW-1:0] i_wtag,
    input  logic [31:0]      i_wdata,
    output logic             o_ok,
    output logic [31:0]      o_dout,
    output logic [MAXAW-1:0] o_tag,
    output logic [WW-1:0]    o_word
);

    logic             r_valid;
    logic [MAXAW-1:0] r_tag;
    logic [31:0]      r_data;
    logic [WW-1:0]    w_a22;

    assign w_a22  = WW'(i_addr);
    assign o_word = map_word(DW, OFFSET, w_a22);
    assign o_ok   = i_cs & r_valid & (r_tag == o_tag);

    // tag is the address with the in-line lane bits removed
    always_comb begin
        o_tag = i_addr;
        unique case (DW)
            DW8:     o_tag = i_addr >> 2;
            DW16:    o_tag = i_addr >> 1;
            default: o_tag = i_addr;
        endcase
    end

    // byte/half lane select out of the cached line
    always_comb begin
        o_dout = r_data;
        unique case (DW)
            DW8:     o_dout = {24'd0, r_data[{i_addr[1:0], 3'd0} +: 8]};
            DW16:    o_dout = {16'd0, r_data[{i_addr[0], 4'd0} +: 16]};
            default: o_dout = r_data;
        endcase
    end

    // line storage; invalidation wins over a fill
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_tag   <= '0;
            r_data  <= '0;
        end else if (i_clr) begin
            r_valid <= 1'b0;
        end else if (i_we) begin
            r_valid <= 1'b1;
            r_tag   <= i_wtag;
            r_data  <= i_wdata;
        end
    end

endmodule

// File: rtl/jtframe_rom_nslot.sv
// N-slot SDRAM ROM arbiter: per-slot line caches, fixed or
// round-robin arbitration with vblank promotion, request FSM.
module jtframe_rom_nslot
    import jtframe_rom_nslot_pkg::*;
#(
    parameter int                   SLOTS       = 4,
    parameter int                   MAXAW       = 18,
    parameter logic [2*SLOTS-1:0]   SLOT_DW     = '0,
    parameter logic [22*SLOTS-1:0]  SLOT_OFFSET = '0,
    parameter bit                   RROBIN      = 1'b0,
    parameter logic [SLOTS-1:0]     VB_MASK     = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   vblank,
    input  logic                   downloading,
    input  logic                   loop_rst,
    input  logic [SLOTS-1:0]       slot_cs,
    input  logic [SLOTS*MAXAW-1:0] slot_addr,
    output logic [SLOTS-1:0]       slot_ok,
    output logic [SLOTS*32-1:0]    slot_dout,
    output logic                   sdram_req,
    input  logic                   sdram_ack,
    input  logic                   data_rdy,
    output logic [21:0]            sdram_addr,
    input  logic [31:0]            data_read,
    output logic                   refresh_en
);

    localparam int SW = SLOTS > 1 ? $clog2(SLOTS) : 1;

    state_t           r_state, w_nx;
    logic [SW-1:0]    r_ptr, r_slot, w_sel, w_ptr_nx;
    logic [MAXAW-1:0] r_tag;
    logic [21:0]      r_addr;
    logic             r_req;

    logic [SLOTS-1:0] w_miss, w_vb, w_cand, w_fill;
    logic [MAXAW-1:0] w_tag  [SLOTS];
    logic [21:0]      w_word [SLOTS];
    logic             w_clr, w_wr, w_go, w_found;

    assign w_clr = downloading | loop_rst;
    assign w_wr  = (r_state == ST_WAIT) & data_rdy & ~w_clr;
    assign w_go  = (r_state == ST_IDLE) & w_found & ~w_clr;

    genvar gi;
    generate
        for (gi = 0; gi < SLOTS; gi++) begin : g_slot
            assign w_fill[gi] = w_wr & (r_slot == SW'(gi));
            assign w_miss[gi] = slot_cs[gi] & ~slot_ok[gi];

            jtframe_rom_slotcache #(
                .MAXAW  (MAXAW),
                .DW     (SLOT_DW[2*gi +: 2]),
                .OFFSET (SLOT_OFFSET[22*gi +: 22])
            ) u_cache (
                .clk     (clk),
                .i_rst   (rst),
                .i_clr   (w_clr),
                .i_cs    (slot_cs[gi]),
                .i_addr  (slot_addr[MAXAW*gi +: MAXAW]),
                .i_we    (w_fill[gi]),
                .i_wtag  (r_tag),
                .i_wdata (data_read),
                .o_ok    (slot_ok[gi]),
                .o_dout  (slot_dout[32*gi +: 32]),
                .o_tag   (w_tag[gi]),
                .o_word  (w_word[gi])
            );
        end
    endgenerate

    // pick the winning miss: vblank group first, then fixed/RR scan
    always_comb begin
        int j;
        j       = 0;
        w_vb    = vblank ? (w_miss & VB_MASK) : '0;
        w_cand  = (|w_vb) ? w_vb : w_miss;
        w_sel   = '0;
        w_found = 1'b0;
        for (int k = 0; k < SLOTS; k++) begin
            j = RROBIN ? int'(r_ptr) + k : k;
            if (j >= SLOTS) j = j - SLOTS;
            if (!w_found && w_cand[j]) begin
                w_found = 1'b1;
                w_sel   = SW'(j);
            end
        end
        w_ptr_nx = (w_sel == SW'(SLOTS-1)) ? '0 : w_sel + 1'b1;
    end

    // request FSM next state
    always_comb begin
        w_nx = r_state;
        unique case (r_state)
            ST_IDLE: if (w_go) w_nx = ST_REQ;
            ST_REQ: begin
                if (w_clr)          w_nx = ST_IDLE;
                else if (sdram_ack) w_nx = ST_WAIT;
            end
            ST_WAIT: if (w_clr || data_rdy) w_nx = ST_IDLE;
            default: w_nx = ST_IDLE;
        endcase
    end

    // state, grant latches and SDRAM request
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_req   <= 1'b0;
            r_addr  <= '0;
            r_slot  <= '0;
            r_tag   <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_nx;
            if (w_go) begin
                r_req  <= 1'b1;
                r_addr <= w_word[w_sel];
                r_slot <= w_sel;
                r_tag  <= w_tag[w_sel];
                if (RROBIN) r_ptr <= w_ptr_nx;
            end else if (r_state == ST_REQ && (w_clr || sdram_ack)) begin
                r_req <= 1'b0;
            end
        end
    end

    assign sdram_req  = r_req;
    assign sdram_addr = r_addr;
    assign refresh_en = (r_state == ST_IDLE) & ~(|w_miss);

endmodule

// File: tb/tb_jtframe_rom_nslot.sv
// Bench for jtframe_rom_nslot: a round-robin and a fixed-priority
// instance share stimulus; grant addresses are scoreboarded.
module tb_jtframe_rom_nslot;

    localparam int N  = 4;
    localparam int AW = 18;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          vblank, downloading, loop_rst;
    logic [N-1:0]  slot_cs;
    logic [AW-1:0] addr [N];
    logic [N*AW-1:0] slot_addr;
    assign slot_addr = {addr[3], addr[2], addr[1], addr[0]};

    logic [N-1:0]    ok     [2];
    logic [N*32-1:0] dout   [2];
    logic            req    [2];
    logic            ack    [2];
    logic            rdy    [2];
    logic [21:0]     saddr  [2];
    logic [31:0]     rdat   [2];
    logic            ref_en [2];

    int checks = 0;
    int errors = 0;

    logic [21:0] q0 [$];
    logic [21:0] q1 [$];
    int          rs [2];
    logic [21:0] la [2];
    logic [21:0] e;

    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : g_dut
            jtframe_rom_nslot #(
                .SLOTS       (N),
                .MAXAW       (AW),
                .SLOT_DW     (8'b00_01_10_00),
                .SLOT_OFFSET ({22'h100, 22'h20000, 22'h20000, 22'h0}),
                .RROBIN      (g == 0),
                .VB_MASK     (4'b1000)
            ) u_dut (
                .clk         (clk),
                .rst         (rst),
                .vblank      (vblank),
                .downloading (downloading),
                .loop_rst    (loop_rst),
                .slot_cs     (slot_cs),
                .slot_addr   (slot_addr),
                .slot_ok     (ok[g]),
                .slot_dout   (dout[g]),
                .sdram_req   (req[g]),
                .sdram_ack   (ack[g]),
                .data_rdy    (rdy[g]),
                .sdram_addr  (saddr[g]),
                .data_read   (rdat[g]),
                .refresh_en  (ref_en[g])
            );
        end
    endgenerate

    function automatic logic [15:0] mem(input logic [21:0] w);
        if (w == 22'd0) return 16'h2211;
        if (w == 22'd1) return 16'h4433;
        return {8'h5A, w[7:0]};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [21:0] a0, input logic [21:0] a1);
        q0.push_back(a0);
        q1.push_back(a1);
    endtask

    // SDRAM model and grant monitor for both instances
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                rs[i] = 0; ack[i] = 1'b0; rdy[i] = 1'b0;
                rdat[i] = '0; la[i] = '0;
            end else begin
                case (rs[i])
                    0: if (req[i]) begin
                        if ((i == 0 ? q0.size() : q1.size()) == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_req dut%0d got %0h want none",
                                     i, saddr[i]);
                        end else begin
                            e = (i == 0) ? q0.pop_front() : q1.pop_front();
                            chk($sformatf("grant_addr dut%0d", i), saddr[i], e);
                        end
                        la[i] = saddr[i];
                        ack[i] = 1'b1;
                        rs[i] = 1;
                    end
                    1: begin ack[i] = 1'b0; rs[i] = 2; end
                    2: rs[i] = 3;
                    3: begin
                        rdy[i]  = 1'b1;
                        rdat[i] = {mem(la[i] + 22'd1), mem(la[i])};
                        rs[i]   = 4;
                    end
                    default: begin rdy[i] = 1'b0; rs[i] = 0; end
                endcase
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic samp();
        @(negedge clk); #2;
    endtask

    task automatic wait_ok(input int s, input logic [31:0] exp);
        for (int i = 0; i < 2; i++) begin
            int c;
            c = 0;
            samp();
            while (!ok[i][s] && c < 80) begin samp(); c++; end
            chk($sformatf("ok dut%0d s%0d", i, s), ok[i][s], 1);
            chk($sformatf("dout dut%0d s%0d", i, s), dout[i][32*s +: 32], exp);
        end
    endtask

    task automatic wait_ack();
        int c;
        c = 0;
        samp();
        while (!ack[0] && c < 40) begin samp(); c++; end
        chk("ack_seen", ack[0], 1);
    endtask

    task automatic wait_rdy();
        int c;
        c = 0;
        samp();
        while (!rdy[0] && c < 40) begin samp(); c++; end
        chk("rdy_seen", rdy[0], 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nreq [2];
        vblank = 0; downloading = 0; loop_rst = 0; slot_cs = '0;
        for (int i = 0; i < N; i++) addr[i] = '0;
        repeat (3) tick();
        samp();
        for (int i = 0; i < 2; i++) begin
            chk("rst_req",  req[i],    0);
            chk("rst_addr", saddr[i],  0);
            chk("rst_ok",   ok[i],     0);
            chk("rst_dout", dout[i],   0);
            chk("rst_ref",  ref_en[i], 1);
        end
        tick(); rst = 0;

        // DW8 line fill and in-line hit
        tick(); addr[0] = 18'h3; slot_cs = 4'b0001;
        push(22'h0, 22'h0);
        wait_ok(0, 32'h44);
        tick(); addr[0] = 18'h2;
        samp();
        for (int i = 0; i < 2; i++) begin
            chk("t1_hit_ok",   ok[i][0], 1);
            chk("t1_hit_dout", dout[i][31:0], 32'h33);
            chk("t1_ref",      ref_en[i], 1);
        end
        repeat (5) samp();
        for (int i = 0; i < 2; i++) chk("t1_noreq", req[i], 0);

        // DW32 and DW16 mapping with offset
        tick(); slot_cs = 4'b0010; addr[1] = 18'h5;
        push(22'h2000A, 22'h2000A);
        wait_ok(1, 32'h5A0B5A0A);
        tick(); slot_cs = 4'b0100; addr[2] = 18'h7;
        push(22'h20006, 22'h20006);
        wait_ok(2, 32'h00005A07);

        // three slots miss together
        tick(); slot_cs = 4'b0111;
        addr[0] = 18'h10; addr[1] = 18'h100; addr[2] = 18'h41;
        push(22'h8, 22'h8);
        push(22'h20200, 22'h20200);
        push(22'h20040, 22'h20040);
        wait_ok(0, 32'h08);
        wait_ok(1, 32'h5A015A00);
        wait_ok(2, 32'h5A41);
        tick(); addr[0] = 18'h20;
        push(22'h10, 22'h10);
        wait_ok(0, 32'h10);
        // RR pointer now past slot0; fixed keeps slot0 first
        tick(); addr[0] = 18'h30; addr[1] = 18'h101;
        push(22'h20202, 22'h18);
        push(22'h18, 22'h20202);
        wait_ok(0, 32'h18);
        wait_ok(1, 32'h5A035A02);
        tick(); addr[0] = 18'h40; addr[1] = 18'h102;
        push(22'h20204, 22'h20);
        push(22'h20, 22'h20204);
        wait_ok(0, 32'h20);
        wait_ok(1, 32'h5A055A04);

        // vblank promotion of slot 3
        tick(); slot_cs = 4'b1001; vblank = 1;
        addr[0] = 18'h50; addr[3] = 18'h8;
        push(22'h104, 22'h104);
        push(22'h28, 22'h28);
        wait_ok(3, 32'h04);
        wait_ok(0, 32'h28);
        tick(); vblank = 0; addr[0] = 18'h60; addr[3] = 18'hC;
        push(22'h106, 22'h30);
        push(22'h30, 22'h106);
        wait_ok(0, 32'h30);
        wait_ok(3, 32'h06);

        // address change while waiting for data
        tick(); slot_cs = 4'b0001; addr[0] = 18'h70;
        push(22'h38, 22'h38);
        push(22'h40, 22'h40);
        wait_ack();
        tick(); addr[0] = 18'h80;
        samp();
        for (int i = 0; i < 2; i++) chk("t5_new_miss", ok[i][0], 0);
        wait_rdy();
        tick();
        for (int i = 0; i < 2; i++) chk("t5_stale", ok[i][0], 0);
        wait_ok(0, 32'h40);

        // loop_rst while waiting for data
        tick(); addr[0] = 18'h90;
        push(22'h48, 22'h48);
        push(22'h48, 22'h48);
        wait_ack();
        tick(); loop_rst = 1;
        tick(); loop_rst = 0;
        for (int i = 0; i < 2; i++) chk("t6_ok_clr", ok[i], 0);
        wait_rdy();
        tick();
        for (int i = 0; i < 2; i++) chk("t6_rdy_ignored", ok[i][0], 0);
        wait_ok(0, 32'h48);
        tick(); slot_cs = 4'b1111;
        push(22'h20204, 22'h20204);
        push(22'h20040, 22'h20040);
        push(22'h106, 22'h106);
        wait_ok(1, 32'h5A055A04);
        wait_ok(2, 32'h5A41);
        wait_ok(3, 32'h06);

        // downloading blocks requests and invalidates
        tick(); downloading = 1;
        tick();
        nreq[0] = 0; nreq[1] = 0;
        repeat (20) begin
            samp();
            for (int i = 0; i < 2; i++) if (req[i]) nreq[i]++;
        end
        for (int i = 0; i < 2; i++) begin
            chk("dl_noreq", nreq[i], 0);
            chk("dl_ok",    ok[i], 0);
            chk("dl_ref",   ref_en[i], 0);
        end
        tick(); downloading = 0; slot_cs = 4'b0000;
        samp();
        for (int i = 0; i < 2; i++) chk("idle_ref", ref_en[i], 1);
        tick(); slot_cs = 4'b0001;
        push(22'h48, 22'h48);
        wait_ok(0, 32'h48);

        repeat (10) samp();
        chk("q0_left", q0.size(), 0);
        chk("q1_left", q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
